dlx_run_ctrl: RTL and testbench
===============================

Name: dlx_run_ctrl

Overview:
- Parametrised run-control and debug-view block between the board clock and the DLX pipeline.
- Replaces the fixed divide-by-2 clock toggle and hard-wired regs3 output.
- Generates a programmable-rate CPU clock-enable with halt/run/single-step modes and a cycle counter.
- Presents a snapshot of any selected architectural register on the board display outputs.

Parameters:
- DIV_W, 24: width of divide-ratio input and tick counter.
- DATA_W, 32: register width.
- NREGS, 32: number of architectural registers on regs_flat_i.
- SEL_W, 5: register-select width; must satisfy 2**SEL_W >= NREGS.
- VIEW_W, 14: display output width, taken from snapshot LSBs.

Ports:
- clock  in  1  board clock; sole clock domain.
- reset_i  in  1  synchronous, active-high reset.
- mode_i  in  2  00 HALT, 01 RUN, 10 STEP, 11 treated as HALT.
- step_i  in  1  asynchronous push-button level.
- div_i  in  DIV_W  ticks occur every max(div_i,1) clocks.
- reg_sel_i  in  SEL_W  register to view.
- regs_flat_i  in  NREGS*DATA_W  register file, reg k at bits [k*DATA_W +: DATA_W].
- pc_i  in  DATA_W  current fetch PC from pipeline.
- cpu_ce_o  out  1  one-clock enable pulse; pipeline advances one cycle per pulse.
- cpu_clk_o  out  1  legacy square clock; toggles on every issued pulse.
- view_o  out  VIEW_W  snapshot[VIEW_W-1:0].
- cycle_cnt_o  out  32  count of issued pulses.
- running_o  out  1  high in state RUN.

Behaviour:
- Reset (synchronous, active-high, clock domain only): all outputs 0, tick counter 0, state HALT, step synchroniser 0, snapshot 0. Reset mid-pulse aborts; no pulse on the cycle following reset.
- Tick generator:
  - cnt increments every clock.
  - When cnt >= max(div_i,1)-1: tick=1 and cnt<=0.
  - Runtime div_i change applies immediately via the >= compare. Lowering div_i below cnt gives a tick next cycle, no wrap.
  - div_i=0 or 1: tick every clock.
- step_i: 2-FF synchroniser plus edge register. step_rise = sync & ~prev; latency 3 clocks from input edge.
- FSM states: HALT, RUN, STEP_WAIT, STEP_FIRE.
  - HALT: mode_i=01 -> RUN; mode_i=10 -> STEP_WAIT.
  - RUN: cpu_ce_o=tick. mode_i!=01 -> HALT, or STEP_WAIT if mode_i=10. Mode change on a tick cycle still issues that tick's pulse (registered decision).
  - STEP_WAIT: step_rise -> STEP_FIRE; mode_i=01 -> RUN; mode_i 00/11 -> HALT.
  - STEP_FIRE: on tick issue exactly one pulse, then STEP_WAIT. Further step_rise while in STEP_FIRE is ignored (no queuing). Mode change before the tick cancels the step.
- cpu_ce_o is registered: asserted the clock after the tick decision, width exactly 1 clock.
- cpu_clk_o inverts on each cycle cpu_ce_o=1.
- cycle_cnt_o += 1 per pulse; wraps 0xFFFFFFFF -> 0.
- Snapshot: latched from regs_flat_i[reg_sel_i] the clock after a pulse, or the clock after reg_sel_i changes.
  - reg_sel_i >= NREGS yields 0.
  - view_o updates 1 clock after the snapshot.

Optional Feature:
- Macro: DLX_RUN_CTRL_BREAKPOINT_EN.
- When defined:
  - Extra ports bp_en_i (1) and bp_addr_i (DATA_W), plus output bp_hit_o (1).
  - In RUN, a pulse issued while bp_en_i=1 and pc_i==bp_addr_i forces HALT on the next clock, regardless of mode_i.
  - bp_hit_o is a sticky flag, set in that case and cleared by reset_i or by mode_i=00.
  - Leaving HALT after a hit requires mode_i to pass through 00.
- When undefined: ports absent; behaviour as above.

Decomposition:
- Package dlx_dbg_pkg holds:
  - mode encodings MODE_HALT/RUN/STEP.
  - FSM state enum.
  - default DIV value 4500000.
- One natural sub-module: dlx_tick_gen (counter + compare, outputs tick).
- Step synchroniser and FSM stay inline.

Test Plan:
- Reset, mode_i=01, div_i=4 -> first cpu_ce_o 4 clocks after the RUN entry tick boundary, then every 4 clocks. cycle_cnt_o=5 after 20 clocks. running_o=1.
- mode_i=10, one step_i pulse 10 clocks wide, div_i=3 -> exactly one cpu_ce_o, cycle_cnt_o=1. cpu_clk_o toggles once. A second press gives cycle_cnt_o=2.
- RUN with div_i=100, cnt at 60, div_i changed to 10 -> tick next clock, then every 10.
- regs_flat_i reg7=0x0000ABCD, reg_sel_i=7 -> view_o=0x2BCD (14 LSBs) within 2 clocks. reg_sel_i=7 held with NREGS=16 and reg_sel_i=20 -> view_o=0.
- RUN, reset_i asserted for 1 clock mid-stream -> next clock all outputs 0, state HALT, no pulses until mode_i re-sampled as 01.
- (BREAKPOINT_EN) bp_addr_i=0x40, bp_en_i=1, pc_i reaches 0x40 under RUN -> cpu_ce_o stops after that pulse. bp_hit_o=1, running_o=0. Mode 01 without passing 00 keeps HALT.

Source files
------------

// File: rtl/dlx_dbg_pkg.sv
// Shared encodings for the DLX run-control block.
// Mode codes, FSM state codes and the board default divide ratio.
package dlx_dbg_pkg;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  localparam logic [1:0] ST_HALT      = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_STEP_WAIT = 2'd2;
  localparam logic [1:0] ST_STEP_FIRE = 2'd3;

  localparam int unsigned DIV_DEFAULT = 4500000;

endpackage

// File: rtl/dlx_tick_gen.sv
// Programmable-rate tick: one-clock tick every max(div_i,1) clocks.
// A >= compare lets div_i change at runtime without wrapping.
module dlx_tick_gen #(
  parameter int DIV_W = 24
) (
  input  logic             clock,
  input  logic             reset_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] lim;

  always_comb begin
    lim    = (div_i == '0) ? '0 : div_i - ONE;
    tick_o = (cnt_q >= lim);
    cnt_d  = tick_o ? '0 : cnt_q + ONE;
  end

  always_ff @(posedge clock) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dlx_run_ctrl.sv
// DLX run control: halt/run/step clock-enable, cycle count, reg view.
// Optional breakpoint halt enabled by DLX_RUN_CTRL_BREAKPOINT_EN.
module dlx_run_ctrl
  import dlx_dbg_pkg::*;
#(
  parameter int DIV_W  = 24,
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int SEL_W  = 5,
  parameter int VIEW_W = 14
) (
  input  logic                    clock,
  input  logic                    reset_i,
  input  logic [1:0]              mode_i,
  input  logic                    step_i,
  input  logic [DIV_W-1:0]        div_i,
  input  logic [SEL_W-1:0]        reg_sel_i,
  input  logic [NREGS*DATA_W-1:0] regs_flat_i,
  input  logic [DATA_W-1:0]       pc_i,
`ifdef DLX_RUN_CTRL_BREAKPOINT_EN
  input  logic                    bp_en_i,
  input  logic [DATA_W-1:0]       bp_addr_i,
  output logic                    bp_hit_o,
`endif
  output logic                    cpu_ce_o,
  output logic                    cpu_clk_o,
  output logic [VIEW_W-1:0]       view_o,
  output logic [31:0]             cycle_cnt_o,
  output logic                    running_o
);

  logic tick;

  dlx_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clock   (clock),
    .reset_i (reset_i),
    .div_i   (div_i),
    .tick_o  (tick)
  );

  logic [2:0]        step_q;
  logic              step_rise;
  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic              ce_q;
  logic              ce_d;
  logic              clk_q;
  logic [31:0]       cyc_q;
  logic [DATA_W-1:0] snap_q;
  logic [DATA_W-1:0] snap_d;
  logic [DATA_W-1:0] snap_src;
  logic [VIEW_W-1:0] view_q;
  logic [SEL_W-1:0]  sel_q;
  logic [31:0]       sel_ext;
  logic              halt_lock;
  logic              bp_trip;

  // step_q[1] is the synchronised level, step_q[2] its previous value
  assign step_rise = step_q[1] & ~step_q[2];

`ifdef DLX_RUN_CTRL_BREAKPOINT_EN
  logic bp_hit_q;
  logic bp_hit_d;

  assign bp_trip   = (state_q == ST_RUN) & ce_q & bp_en_i
                   & (pc_i == bp_addr_i);
  assign halt_lock = bp_hit_q;
  assign bp_hit_o  = bp_hit_q;

  always_comb begin
    bp_hit_d = bp_hit_q;
    if (bp_trip)                 bp_hit_d = 1'b1;
    else if (mode_i == MODE_HALT) bp_hit_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset_i) bp_hit_q <= 1'b0;
    else         bp_hit_q <= bp_hit_d;
  end
`else
  logic unused_pc;

  assign unused_pc = ^pc_i;
  assign bp_trip   = 1'b0;
  assign halt_lock = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ce_d    = 1'b0;
    unique case (state_q)
      ST_HALT: begin
        if (!halt_lock) begin
          if (mode_i == MODE_RUN)       state_d = ST_RUN;
          else if (mode_i == MODE_STEP) state_d = ST_STEP_WAIT;
        end
      end
      ST_RUN: begin
        ce_d = tick;
        if (mode_i == MODE_STEP)     state_d = ST_STEP_WAIT;
        else if (mode_i != MODE_RUN) state_d = ST_HALT;
        if (bp_trip) begin
          ce_d    = 1'b0;
          state_d = ST_HALT;
        end
      end
      ST_STEP_WAIT: begin
        if (mode_i == MODE_RUN)       state_d = ST_RUN;
        else if (mode_i != MODE_STEP) state_d = ST_HALT;
        else if (step_rise)           state_d = ST_STEP_FIRE;
      end
      ST_STEP_FIRE: begin
        if (mode_i == MODE_RUN)       state_d = ST_RUN;
        else if (mode_i != MODE_STEP) state_d = ST_HALT;
        else if (tick) begin
          ce_d    = 1'b1;
          state_d = ST_STEP_WAIT;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_comb begin
    sel_ext            = '0;
    sel_ext[SEL_W-1:0] = reg_sel_i;
    snap_src           = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (sel_ext == k) snap_src = regs_flat_i[k*DATA_W +: DATA_W];
    end
    snap_d = (ce_q || reg_sel_i != sel_q) ? snap_src : snap_q;
  end

  always_ff @(posedge clock) begin
    if (reset_i) begin
      step_q  <= '0;
      state_q <= ST_HALT;
      ce_q    <= 1'b0;
      clk_q   <= 1'b0;
      cyc_q   <= '0;
      snap_q  <= '0;
      view_q  <= '0;
      sel_q   <= '0;
    end else begin
      step_q  <= {step_q[1:0], step_i};
      state_q <= state_d;
      ce_q    <= ce_d;
      clk_q   <= clk_q ^ ce_d;
      cyc_q   <= cyc_q + {31'd0, ce_d};
      snap_q  <= snap_d;
      view_q  <= snap_q[VIEW_W-1:0];
      sel_q   <= reg_sel_i;
    end
  end

  assign cpu_ce_o    = ce_q;
  assign cpu_clk_o   = clk_q;
  assign view_o      = view_q;
  assign cycle_cnt_o = cyc_q;
  assign running_o   = (state_q == ST_RUN);

endmodule

// File: tb/tb_dlx_run_ctrl.sv
// Directed bench for dlx_run_ctrl (NREGS=16 to reach out-of-range selects).
// Breakpoint steps compile only with DLX_RUN_CTRL_BREAKPOINT_EN.
module tb_dlx_run_ctrl;

  localparam int NR = 16;

  logic           clock = 1'b0;
  logic           reset_i;
  logic [1:0]     mode_i;
  logic           step_i;
  logic [23:0]    div_i;
  logic [4:0]     reg_sel_i;
  logic [NR*32-1:0] regs;
  logic [31:0]    pc_i;
  logic           cpu_ce_o;
  logic           cpu_clk_o;
  logic [13:0]    view_o;
  logic [31:0]    cycle_cnt_o;
  logic           running_o;
`ifdef DLX_RUN_CTRL_BREAKPOINT_EN
  logic           bp_en_i;
  logic [31:0]    bp_addr_i;
  logic           bp_hit_o;
`endif

  int vecs = 0;
  int errs = 0;
  int ce_seen;

  always #5 clock = ~clock;

  // pulse k executes at pc 0x2C + 4*k
  assign pc_i = 32'h2C + (cycle_cnt_o << 2);

  dlx_run_ctrl #(
    .DIV_W(24), .DATA_W(32), .NREGS(NR),
    .SEL_W(5), .VIEW_W(14)
  ) dut (
    .clock       (clock),
    .reset_i     (reset_i),
    .mode_i      (mode_i),
    .step_i      (step_i),
    .div_i       (div_i),
    .reg_sel_i   (reg_sel_i),
    .regs_flat_i (regs),
    .pc_i        (pc_i),
`ifdef DLX_RUN_CTRL_BREAKPOINT_EN
    .bp_en_i     (bp_en_i),
    .bp_addr_i   (bp_addr_i),
    .bp_hit_o    (bp_hit_o),
`endif
    .cpu_ce_o    (cpu_ce_o),
    .cpu_clk_o   (cpu_clk_o),
    .view_o      (view_o),
    .cycle_cnt_o (cycle_cnt_o),
    .running_o   (running_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic cyc_count(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      ce_seen += int'(cpu_ce_o);
    end
  endtask

  initial begin
    reset_i   = 1'b1;
    mode_i    = 2'b00;
    step_i    = 1'b0;
    div_i     = 24'd4;
    reg_sel_i = 5'd0;
    for (int k = 0; k < NR; k++)
      regs[k*32 +: 32] = 32'h5A5A_1000 + k * 32'h0101;
`ifdef DLX_RUN_CTRL_BREAKPOINT_EN
    bp_en_i   = 1'b0;
    bp_addr_i = 32'h40;
`endif

    cyc(2);
    chk("rst_ce", 32'(cpu_ce_o), 32'd0);
    chk("rst_clk", 32'(cpu_clk_o), 32'd0);
    chk("rst_view", 32'(view_o), 32'd0);
    chk("rst_cnt", cycle_cnt_o, 32'd0);
    chk("rst_run", 32'(running_o), 32'd0);

    // RUN at div 4: pulses after clocks 4, 8, 12, 16, 20
    reset_i = 1'b0;
    mode_i  = 2'b01;
    for (int n = 1; n <= 20; n++) begin
      cyc(1);
      chk("run_ce", 32'(cpu_ce_o), (n % 4 == 0) ? 32'd1 : 32'd0);
    end
    chk("run_cnt", cycle_cnt_o, 32'd5);
    chk("run_running", 32'(running_o), 32'd1);
    chk("run_clk", 32'(cpu_clk_o), 32'd1);
    chk("run_view0", 32'(view_o), 32'h1000);

    // reset in the middle of a pulse
    reset_i = 1'b1;
    cyc(1);
    chk("mrst_ce", 32'(cpu_ce_o), 32'd0);
    chk("mrst_cnt", cycle_cnt_o, 32'd0);
    chk("mrst_clk", 32'(cpu_clk_o), 32'd0);
    chk("mrst_run", 32'(running_o), 32'd0);
    chk("mrst_view", 32'(view_o), 32'd0);
    reset_i = 1'b0;
    mode_i  = 2'b00;
    ce_seen = 0;
    cyc_count(6);
    chk("mrst_nopulse", ce_seen, 0);
    chk("mrst_halt", 32'(running_o), 32'd0);

    // single step at div 3
    mode_i = 2'b10;
    div_i  = 24'd3;
    cyc(2);
    chk("step_wait_run", 32'(running_o), 32'd0);
    ce_seen = 0;
    step_i  = 1'b1;
    cyc_count(10);
    step_i  = 1'b0;
    cyc_count(15);
    chk("step1_pulses", ce_seen, 1);
    chk("step1_cnt", cycle_cnt_o, 32'd1);
    chk("step1_clk", 32'(cpu_clk_o), 32'd1);
    ce_seen = 0;
    step_i  = 1'b1;
    cyc_count(4);
    step_i  = 1'b0;
    cyc_count(15);
    chk("step2_pulses", ce_seen, 1);
    chk("step2_cnt", cycle_cnt_o, 32'd2);
    chk("step2_clk", 32'(cpu_clk_o), 32'd0);

    // divide change from 100 to 10 with the counter at 60
    reset_i = 1'b1;
    mode_i  = 2'b01;
    div_i   = 24'd100;
    cyc(1);
    reset_i = 1'b0;
    ce_seen = 0;
    cyc_count(60);
    chk("div_quiet", ce_seen, 0);
    div_i = 24'd10;
    cyc(1);
    chk("div_first", 32'(cpu_ce_o), 32'd1);
    ce_seen = 0;
    cyc_count(9);
    chk("div_gap", ce_seen, 0);
    cyc(1);
    chk("div_second", 32'(cpu_ce_o), 32'd1);
    chk("div_cnt", cycle_cnt_o, 32'd2);

    // register view
    mode_i = 2'b00;
    cyc(3);
    regs[7*32 +: 32] = 32'h0000_ABCD;
    reg_sel_i = 5'd7;
    cyc(2);
    chk("view_r7", 32'(view_o), 32'h2BCD);
    reg_sel_i = 5'd20;
    cyc(2);
    chk("view_r20", 32'(view_o), 32'd0);
    reg_sel_i = 5'd15;
    cyc(2);
    chk("view_r15", 32'(view_o), 32'h1F0F);
    reg_sel_i = 5'd16;
    cyc(2);
    chk("view_r16", 32'(view_o), 32'd0);
    reg_sel_i = 5'd7;
    cyc(2);
    chk("view_r7b", 32'(view_o), 32'h2BCD);
    regs[7*32 +: 32] = 32'h0000_1234;
    cyc(3);
    chk("view_hold", 32'(view_o), 32'h2BCD);
    mode_i = 2'b01;
    div_i  = 24'd1;
    cyc(5);
    chk("view_pulse", 32'(view_o), 32'h1234);
    mode_i = 2'b00;
    cyc(2);

`ifdef DLX_RUN_CTRL_BREAKPOINT_EN
    reset_i = 1'b1;
    mode_i  = 2'b01;
    div_i   = 24'd1;
    bp_en_i = 1'b1;
    cyc(1);
    reset_i = 1'b0;
    cyc(15);
    chk("bp_cnt", cycle_cnt_o, 32'd5);
    chk("bp_hit", 32'(bp_hit_o), 32'd1);
    chk("bp_run", 32'(running_o), 32'd0);
    cyc(5);
    chk("bp_lock", 32'(running_o), 32'd0);
    chk("bp_lock_cnt", cycle_cnt_o, 32'd5);
    mode_i = 2'b00;
    cyc(1);
    chk("bp_clear", 32'(bp_hit_o), 32'd0);
    mode_i = 2'b01;
    cyc(1);
    chk("bp_resume", 32'(running_o), 32'd1);
    mode_i = 2'b00;
    cyc(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
